// File: rtl/collision_frame_tracker.sv
// rtl/collision_frame_tracker.sv - per-frame sprite collision detector with cooldown-filtered hit events
// Optional COLLISION_COORD_EN builds first-hit coordinate capture; without it hit_x/hit_y read 0.
module collision_frame_tracker #(
    parameter int                    SIZE     = 9,
    parameter int                    NPAIR    = 2,
    parameter logic [NPAIR*SIZE-1:0] MASK_A   = {9'h1E0, 9'h008},
    parameter logic [NPAIR*SIZE-1:0] MASK_B   = {9'h001, 9'h001},
    parameter int                    COOLDOWN = 60
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SIZE-1:0]     draw,
    input  logic [9:0]          pxl_x,
    input  logic [8:0]          pxl_y,
    input  logic                vsync,
    output logic [NPAIR-1:0]    hit_pulse,
    output logic [NPAIR-1:0]    hit_frame,
    output logic [NPAIR*8-1:0]  hit_count,
    output logic [NPAIR*10-1:0] hit_x,
    output logic [NPAIR*9-1:0]  hit_y
);
    localparam int             CDW     = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);
    localparam logic [CDW-1:0] CD_LOAD = CDW'(COOLDOWN);

    logic [NPAIR-1:0] ovl_q, ovl_d;
    logic             vsync_dly_q;
    logic             frame_edge;
    logic [NPAIR-1:0] acc_q, acc_d;
    logic [NPAIR-1:0] frame_q, frame_d;
    logic [NPAIR-1:0] pulse_q, pulse_d;
    logic [NPAIR-1:0] frame_hit, fire;
    logic [CDW-1:0]   cd_q [NPAIR];
    logic [CDW-1:0]   cd_d [NPAIR];
    logic [7:0]       count_q [NPAIR];
    logic [7:0]       count_d [NPAIR];

    assign frame_edge = vsync & ~vsync_dly_q;

    always_comb begin
        ovl_d = '0;
        for (int p = 0; p < NPAIR; p++) begin
            ovl_d[p] = (|(draw & MASK_A[p*SIZE +: SIZE])) & (|(draw & MASK_B[p*SIZE +: SIZE]));
        end
    end

    // An overlap still in ovl_q on the edge cycle belongs to the frame being closed.
    always_comb begin
        acc_d     = acc_q;
        frame_d   = frame_q;
        pulse_d   = '0;
        frame_hit = '0;
        fire      = '0;
        cd_d      = cd_q;
        count_d   = count_q;
        for (int p = 0; p < NPAIR; p++) begin
            frame_hit[p] = acc_q[p] | ovl_q[p];
            fire[p]      = frame_hit[p] & (cd_q[p] == '0);
            if (frame_edge) begin
                acc_d[p]   = 1'b0;
                frame_d[p] = frame_hit[p];
                pulse_d[p] = fire[p];
                if (fire[p]) begin
                    cd_d[p] = CD_LOAD;
                    if (count_q[p] != 8'hFF) begin
                        count_d[p] = count_q[p] + 8'd1;
                    end
                end else if (cd_q[p] != '0) begin
                    cd_d[p] = cd_q[p] - CDW'(1);
                end
            end else begin
                acc_d[p] = frame_hit[p];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovl_q       <= '0;
            vsync_dly_q <= 1'b1;
            acc_q       <= '0;
            frame_q     <= '0;
            pulse_q     <= '0;
            for (int p = 0; p < NPAIR; p++) begin
                cd_q[p]    <= '0;
                count_q[p] <= '0;
            end
        end else begin
            ovl_q       <= ovl_d;
            vsync_dly_q <= vsync;
            acc_q       <= acc_d;
            frame_q     <= frame_d;
            pulse_q     <= pulse_d;
            cd_q        <= cd_d;
            count_q     <= count_d;
        end
    end

    assign hit_pulse = pulse_q;
    assign hit_frame = frame_q;

    always_comb begin
        hit_count = '0;
        for (int p = 0; p < NPAIR; p++) begin
            hit_count[p*8 +: 8] = count_q[p];
        end
    end

`ifdef COLLISION_COORD_EN
    logic [9:0] x_q;
    logic [8:0] y_q;
    logic [9:0] cap_x_q [NPAIR];
    logic [9:0] cap_x_d [NPAIR];
    logic [8:0] cap_y_q [NPAIR];
    logic [8:0] cap_y_d [NPAIR];
    logic [9:0] hx_q [NPAIR];
    logic [9:0] hx_d [NPAIR];
    logic [8:0] hy_q [NPAIR];
    logic [8:0] hy_d [NPAIR];
    logic [NPAIR-1:0] first_hit;

    // The first overlap of a frame may land on the edge cycle itself, so bypass cap then.
    always_comb begin
        cap_x_d   = cap_x_q;
        cap_y_d   = cap_y_q;
        hx_d      = hx_q;
        hy_d      = hy_q;
        first_hit = '0;
        for (int p = 0; p < NPAIR; p++) begin
            first_hit[p] = ovl_q[p] & ~acc_q[p];
            if (frame_edge) begin
                hx_d[p]    = first_hit[p] ? x_q : cap_x_q[p];
                hy_d[p]    = first_hit[p] ? y_q : cap_y_q[p];
                cap_x_d[p] = '0;
                cap_y_d[p] = '0;
            end else if (first_hit[p]) begin
                cap_x_d[p] = x_q;
                cap_y_d[p] = y_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
            for (int p = 0; p < NPAIR; p++) begin
                cap_x_q[p] <= '0;
                cap_y_q[p] <= '0;
                hx_q[p]    <= '0;
                hy_q[p]    <= '0;
            end
        end else begin
            x_q     <= pxl_x;
            y_q     <= pxl_y;
            cap_x_q <= cap_x_d;
            cap_y_q <= cap_y_d;
            hx_q    <= hx_d;
            hy_q    <= hy_d;
        end
    end

    always_comb begin
        hit_x = '0;
        hit_y = '0;
        for (int p = 0; p < NPAIR; p++) begin
            hit_x[p*10 +: 10] = hx_q[p];
            hit_y[p*9 +: 9]   = hy_q[p];
        end
    end
`else
    logic unused_coord;
    assign unused_coord = ^{pxl_x, pxl_y};
    assign hit_x = '0;
    assign hit_y = '0;
`endif

endmodule
